drum_timing: RTL

- Generates the drum bit-time and word-time reference for the G-15 memory system.
- Free-running bit counter (T1..T29) and word counter (0..107) derived from CLOCK, one CLOCK per drum bit.
- Feeds the memory-line, source/destination decode and early-bus stages with decoded timing pulses, word number, short-line (4-word) phase and even/odd word flags.
- Optional external index mark re-aligns the counters; misalignment is flagged as a slip.

---
 rtl/drum_timing.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/drum_timing.sv
// drum_timing: G-15 drum bit-time (T1..T29) and word-time (0..107) reference generator.
// Optional macro DRUM_TIMING_MISSING_INDEX_EN adds the NOINDEX missing-index-mark flag.
`default_nettype none

module drum_timing #(
  parameter int BITS_PER_WORD  = 29,
  parameter int WORDS_PER_LINE = 108,
  parameter int SHORT_WORDS    = 4
) (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       INDEX,
  input  logic       SYNC_EN,
  input  logic       CLR_SLIP,
  output logic [4:0] BT,
  output logic [6:0] WT,
  output logic [1:0] WS,
  output logic       T1,
  output logic       T2,
  output logic       T13,
  output logic       T21,
  output logic       T29,
  output logic       ODD,
  output logic       REV,
  output logic       SLIP
`ifdef DRUM_TIMING_MISSING_INDEX_EN
  ,
  output logic       NOINDEX
`endif
);

  localparam logic [4:0] BT_LAST = 5'(BITS_PER_WORD);
  localparam logic [6:0] WT_LAST = 7'(WORDS_PER_LINE - 1);
  localparam logic [1:0] WS_LAST = 2'(SHORT_WORDS - 1);

  logic [4:0] bt_q, bt_d;
  logic [6:0] wt_q, wt_d;
  logic [1:0] ws_q, ws_d;
  logic       t1_q, t1_d, t2_q, t2_d, t13_q, t13_d, t21_q, t21_d, t29_q, t29_d;
  logic       odd_q, odd_d, rev_q, rev_d, slip_q, slip_d;
  logic       illegal, at_end, realign;

  always_comb begin
    illegal = (bt_q == 5'd0) || (bt_q > BT_LAST) || (wt_q > WT_LAST);
    at_end  = (bt_q == BT_LAST) && (wt_q == WT_LAST);
    // An index mark anywhere but the last bit of the revolution, or a corrupted
    // counter, forces the drum back to the start of word 0.
    realign = illegal || (SYNC_EN && INDEX && !at_end);

    bt_d = bt_q;
    wt_d = wt_q;
    ws_d = ws_q;
    if (realign) begin
      bt_d = 5'd1;
      wt_d = 7'd0;
      ws_d = 2'd0;
    end else if (bt_q == BT_LAST) begin
      bt_d = 5'd1;
      if (at_end) begin
        wt_d = 7'd0;
        ws_d = 2'd0;
      end else begin
        wt_d = wt_q + 7'd1;
        ws_d = (ws_q == WS_LAST) ? 2'd0 : ws_q + 2'd1;
      end
    end else begin
      bt_d = bt_q + 5'd1;
    end

    // Decodes use next-state values so they line up with BT/WT in the same cycle.
    t1_d   = (bt_d == 5'd1);
    t2_d   = (bt_d == 5'd2);
    t13_d  = (bt_d == 5'd13);
    t21_d  = (bt_d == 5'd21);
    t29_d  = (bt_d == BT_LAST);
    odd_d  = wt_d[0];
    rev_d  = (wt_d == 7'd0) && (bt_d == 5'd1);
    slip_d = realign ? 1'b1 : (CLR_SLIP ? 1'b0 : slip_q);
  end

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      bt_q   <= 5'd1;
      wt_q   <= 7'd0;
      ws_q   <= 2'd0;
      t1_q   <= 1'b1;
      t2_q   <= 1'b0;
      t13_q  <= 1'b0;
      t21_q  <= 1'b0;
      t29_q  <= 1'b0;
      odd_q  <= 1'b0;
      rev_q  <= 1'b1;
      slip_q <= 1'b0;
    end else begin
      bt_q   <= bt_d;
      wt_q   <= wt_d;
      ws_q   <= ws_d;
      t1_q   <= t1_d;
      t2_q   <= t2_d;
      t13_q  <= t13_d;
      t21_q  <= t21_d;
      t29_q  <= t29_d;
      odd_q  <= odd_d;
      rev_q  <= rev_d;
      slip_q <= slip_d;
    end
  end

  assign BT   = bt_q;
  assign WT   = wt_q;
  assign WS   = ws_q;
  assign T1   = t1_q;
  assign T2   = t2_q;
  assign T13  = t13_q;
  assign T21  = t21_q;
  assign T29  = t29_q;
  assign ODD  = odd_q;
  assign REV  = rev_q;
  assign SLIP = slip_q;

`ifdef DRUM_TIMING_MISSING_INDEX_EN
  logic noindex_q, noindex_d;

  always_comb begin
    noindex_d = (SYNC_EN && at_end && !INDEX) ? 1'b1 : (CLR_SLIP ? 1'b0 : noindex_q);
  end

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      noindex_q <= 1'b0;
    end else begin
      noindex_q <= noindex_d;
    end
  end

  assign NOINDEX = noindex_q;
`endif

endmodule

`default_nettype wire
